// File: rtl/adc_spi_pkg.sv
// Shared types and helpers for the ADC SPI frame receiver.
package adc_spi_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReceive,
        StHold
    } rx_state_e;

    // SPI mode 0 idle levels, also used as filter reset values.
    localparam logic SpiCsIdle   = 1'b1;
    localparam logic SpiSckIdle  = 1'b0;
    localparam logic SpiMosiIdle = 1'b0;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_line_filter.sv
// Two-flop synchroniser followed by a deglitch counter: the output only follows
// the synchronised input once it has held a new level for FILTER_CYCLES samples.
module spi_line_filter
    import adc_spi_pkg::*;
#(
    parameter int unsigned FILTER_CYCLES = 2,
    parameter logic        RESET_VALUE   = 1'b0
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_line,
    output logic o_filtered
);

    localparam int unsigned CntW = cnt_width(FILTER_CYCLES);

    logic            sync1_q, sync2_q;
    logic            filt_q, filt_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync2_q != filt_q) begin
            if (int'(cnt_q) + 1 >= int'(FILTER_CYCLES)) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            sync1_q <= RESET_VALUE;
            sync2_q <= RESET_VALUE;
            filt_q  <= RESET_VALUE;
            cnt_q   <= '0;
        end else begin
            sync1_q <= i_line;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_filtered = filt_q;

endmodule

// File: rtl/adc_spi_frame_rx.sv
// Synchronous SPI slave frame receiver: filtered lines, SCK edge strobe, framing FSM
// and a shadow buffer that is copied to o_data atomically on frame completion.
module adc_spi_frame_rx
    import adc_spi_pkg::*;
#(
    parameter int unsigned WORD_BITS     = 16,
    parameter int unsigned CHANNELS      = 2,
    parameter int unsigned FILTER_CYCLES = 2,
    parameter bit          MSB_FIRST     = 1'b1
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_SPI_CS,
    input  logic                          i_SPI_clock,
    input  logic                          i_SPI_data,
    output logic [CHANNELS*WORD_BITS-1:0] o_data,
    output logic                          o_data_valid,
    output logic                          o_frame_error,
    output logic                          o_busy,
    output logic                          o_cs_stable
);

    localparam int unsigned BitW   = cnt_width(WORD_BITS);
    localparam int unsigned ChW    = cnt_width(CHANNELS);
    localparam int unsigned FrameW = CHANNELS * WORD_BITS;

    localparam logic [BitW-1:0] LastBit = BitW'(WORD_BITS - 1);
    localparam logic [ChW-1:0]  LastCh  = ChW'(CHANNELS - 1);

    logic cs_f, sck_f, mosi_f;

    spi_line_filter #(.FILTER_CYCLES(FILTER_CYCLES), .RESET_VALUE(SpiCsIdle)) u_cs_filter (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_line     (i_SPI_CS),
        .o_filtered (cs_f)
    );

    spi_line_filter #(.FILTER_CYCLES(FILTER_CYCLES), .RESET_VALUE(SpiSckIdle)) u_sck_filter (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_line     (i_SPI_clock),
        .o_filtered (sck_f)
    );

    spi_line_filter #(.FILTER_CYCLES(FILTER_CYCLES), .RESET_VALUE(SpiMosiIdle)) u_mosi_filter (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_line     (i_SPI_data),
        .o_filtered (mosi_f)
    );

    rx_state_e              state_q, state_d;
    logic                   sck_prev_q, cs_prev_q;
    logic [BitW-1:0]        bit_q, bit_d;
    logic [ChW-1:0]         ch_q, ch_d;
    logic [WORD_BITS-1:0]   shift_q, shift_d, shift_next;
    logic [WORD_BITS-1:0]   shadow_q [CHANNELS];
    logic [WORD_BITS-1:0]   shadow_d [CHANNELS];
    logic [FrameW-1:0]      data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   error_q, error_d;
    logic                   sck_rise, cs_fall, frame_done;

    assign sck_rise   = sck_f & ~sck_prev_q;
    assign cs_fall    = ~cs_f & cs_prev_q;
    assign shift_next = MSB_FIRST ? {shift_q[WORD_BITS-2:0], mosi_f}
                                  : {mosi_f, shift_q[WORD_BITS-1:1]};
    assign frame_done = sck_rise && (bit_q == LastBit) && (ch_q == LastCh);

    always_comb begin
        state_d  = state_q;
        bit_d    = bit_q;
        ch_d     = ch_q;
        shift_d  = shift_q;
        shadow_d = shadow_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        error_d  = 1'b0;

        case (state_q)
            StIdle: begin
                if (cs_fall) begin
                    state_d = StReceive;
                    bit_d   = '0;
                    ch_d    = '0;
                    shift_d = '0;
                end
            end
            StReceive: begin
                if (sck_rise) begin
                    shift_d = shift_next;
                    if (bit_q == LastBit) begin
                        bit_d            = '0;
                        ch_d             = ch_q + 1'b1;
                        shadow_d[ch_q]   = shift_next;
                        if (ch_q == LastCh) begin
                            for (int n = 0; n < CHANNELS; n++) begin
                                data_d[n*WORD_BITS +: WORD_BITS] = shadow_d[n];
                            end
                            valid_d = 1'b1;
                            state_d = StHold;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
                // A completing strobe takes priority over a simultaneous CS release.
                if (cs_f && !frame_done) begin
                    error_d = 1'b1;
                    state_d = StIdle;
                end
            end
            StHold: begin
                if (cs_f) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= StIdle;
            sck_prev_q <= SpiSckIdle;
            cs_prev_q  <= SpiCsIdle;
            bit_q      <= '0;
            ch_q       <= '0;
            shift_q    <= '0;
            for (int n = 0; n < CHANNELS; n++) begin
                shadow_q[n] <= '0;
            end
            data_q     <= '0;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sck_prev_q <= sck_f;
            cs_prev_q  <= cs_f;
            bit_q      <= bit_d;
            ch_q       <= ch_d;
            shift_q    <= shift_d;
            shadow_q   <= shadow_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            error_q    <= error_d;
        end
    end

    assign o_data        = data_q;
    assign o_data_valid  = valid_q;
    assign o_frame_error = error_q;
    assign o_busy        = (state_q == StReceive);
    assign o_cs_stable   = cs_f;

endmodule

// File: doc/adc_spi_frame_rx.md
# adc_spi_frame_rx

Parametrised SPI slave receiver for the ADC link: captures framed transfers of CHANNELS words of WORD_BITS bits from an external master, entirely in the i_clock domain. It replaces the two-word, dual-clock receiver with a fully synchronous, deglitched, double-buffered design. Frame-abort detection and an atomic output update guarantee downstream oscillator/mix logic never sees a partially written frame.

## Interface
- WORD_BITS, 16, bits per channel word (4..32)
- CHANNELS, 2, words per frame (1..8)
- FILTER_CYCLES, 2, consecutive equal samples required before a filtered line changes (1..15)
- MSB_FIRST, 1, 1 = first received bit is word MSB; 0 = LSB first
- i_clock  in  1  system clock, all logic on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_SPI_CS  in  1  chip select, active low, asynchronous to i_clock
- i_SPI_clock  in  1  SPI clock, mode 0 (idle low, sample on rising edge)
- i_SPI_data  in  1  MOSI
- o_data  out  CHANNELS*WORD_BITS  received frame; channel n at bits [n*WORD_BITS +: WORD_BITS]
- o_data_valid  out  1  one-cycle pulse when o_data is updated
- o_frame_error  out  1  one-cycle pulse when CS rises mid-frame
- o_busy  out  1  high while a frame is in progress
- o_cs_stable  out  1  filtered CS level

## Operation
- Each input passes through 2-FF synchroniser then deglitch filter: filtered value takes new level only after FILTER_CYCLES consecutive synchronised samples at that level.
- Rising edge of filtered SCK = one-cycle strobe from registered previous filtered value.
- States: IDLE, RECEIVE, HOLD.
- IDLE: filtered CS falling -> RECEIVE; bit counter, channel counter, shift register cleared. SCK edges ignored.
- RECEIVE: each SCK strobe shifts filtered MOSI into shift register (direction per MSB_FIRST). At bit WORD_BITS-1 the word is written to shadow slot [channel], bit counter wraps to 0, channel increments.
- Last bit of channel CHANNELS-1: shadow (including that word) copied to o_data in the same cycle, o_data_valid pulses, -> HOLD.
- HOLD: further SCK strobes ignored; filtered CS rising -> IDLE, no error.
- RECEIVE with filtered CS rising -> o_frame_error pulse, o_data unchanged, shadow discarded, -> IDLE. CS rising and final SCK strobe in same cycle: strobe wins (frame completes, valid pulses, no error), then -> IDLE next cycle.
- CS falling while in HOLD impossible (CS must rise first); CS low at reset release: stay IDLE until a falling edge is seen.
- o_busy = (state == RECEIVE).
- Reset: state IDLE, o_data all zeros, o_data_valid 0, o_frame_error 0, o_busy 0, o_cs_stable 1, filters preset to CS=1, SCK=0, MOSI=0.

## Timing
- Input pin change -> filtered value: 2 + FILTER_CYCLES i_clock cycles (±1 for asynchronous sampling).
- Final SCK rising pin edge -> o_data_valid high: FILTER_CYCLES + 3 cycles (±1).
- CS rising pin edge mid-frame -> o_frame_error: FILTER_CYCLES + 3 cycles (±1).
- Master constraints: SCK high and low each ≥ FILTER_CYCLES + 2 i_clock periods; MOSI stable ≥ FILTER_CYCLES + 2 periods before and 1 after SCK rise; CS low ≥ FILTER_CYCLES + 2 periods before first SCK rise.
- Glitches shorter than FILTER_CYCLES periods on any line produce no effect.
- o_data holds between pulses; only changes in the o_data_valid cycle.

## Structure
- Package adc_spi_pkg: state enum (IDLE, RECEIVE, HOLD), counter width functions ($clog2 of WORD_BITS and CHANNELS, min 1), mode-0 constants.
- Sub-module spi_line_filter (parameters FILTER_CYCLES, RESET_VALUE): synchroniser + deglitch counter, instantiated for CS, SCK, MOSI.
- Top: edge detect, FSM, counters, shift register, shadow array, output register.

## Test plan
- Default params, frame 0x1234, 0xABCD, SCK period 16 cycles -> o_data = 0xABCD1234, one valid pulse at final edge + 5 cycles, no error.
- CS rises after 20 of 32 bits -> o_frame_error pulse, o_data keeps previous 0xABCD1234, next full frame 0x0001, 0x8000 -> 0x80000001.
- 1-cycle glitches on SCK and CS during frame -> ignored, frame received correctly, bit count unaffected.
- 40 SCK edges in one frame -> valid after edge 32, edges 33..40 ignored, o_data = first 32 bits.
- WORD_BITS=12, CHANNELS=4, MSB_FIRST=0, words 0x001,0x800,0xFFF,0x5A5 -> o_data = 0x5A5FFF800001.
- i_reset asserted mid-frame -> o_data 0, o_busy 0, o_cs_stable 1 immediately; no valid/error pulse; next frame received normally.
